// File: rtl/codec_i2c_pkg.sv
// Shared types and constants for the codec control-port I2C responder.
// The valid-register mask is only consulted when CODEC_REG_CHECK_EN is defined.
package codec_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    B1,
    ACK_1,
    B2,
    ACK_2,
    WAIT_STOP
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
  localparam logic [6:0] REG_RESET        = 7'h0F;
  localparam int         NREG             = 16;

  // Registers the codec actually implements: 0..9 plus the reset register 15.
  localparam logic [15:0] REG_VALID_MASK  = 16'h83FF;

  function automatic logic is_valid_reg(input logic [6:0] a);
    return (a[6:4] == 3'd0) && REG_VALID_MASK[a[3:0]];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// I2C line conditioner: 2-flop synchronizers on SCL/SDA plus edge and
// START/STOP pulse generation. Bus idles high, so all flops reset to 1
// to avoid a spurious edge after reset.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;

  // synchronize raw pins and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign sda_lvl  = sda_sync[1];
  assign scl_rise =  scl_sync[1] & ~scl_q;
  assign scl_fall = ~scl_sync[1] &  scl_q;
  // SDA transitions only count as bus conditions while SCL is stably high
  assign start    = scl_sync[1] & scl_q &  sda_q & ~sda_sync[1];
  assign stop     = scl_sync[1] & scl_q & ~sda_q &  sda_sync[1];

endmodule

// File: rtl/codec_i2c_responder.sv
// Write-only I2C target shadowing the audio codec control port.
// Accepts {addr,rw},{reg[6:0],d[8]},{d[7:0]} writes into a 16-entry regfile.
// Optional: define CODEC_REG_CHECK_EN to NACK unimplemented register addresses.
module codec_i2c_responder
  import codec_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_reg_wr,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_busy
);

  logic sda_lvl, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_sync (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .scl      (i_scl),
    .sda      (i_sda),
    .sda_lvl  (sda_lvl),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       ack_ph, ack_ph_n;   // 0: waiting for fall that starts ACK, 1: driving ACK
  logic       sda_oe, sda_oe_n;
  logic [6:0] reg_addr_q;
  logic       d8_q;
  logic       ld_b1, commit;
  logic [7:0] byte_in;
  logic       reg_ok;
  logic [8:0] regfile [NREG];

  assign byte_in = {shreg[6:0], sda_lvl};

`ifdef CODEC_REG_CHECK_EN
  assign reg_ok = is_valid_reg(byte_in[7:1]);
`else
  assign reg_ok = 1'b1;
`endif

  // state register and bit-level bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ack_ph  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      ack_ph  <= ack_ph_n;
      sda_oe  <= sda_oe_n;
    end
  end

  // next-state: bus conditions override everything, then byte/ACK sequencing
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ack_ph_n  = ack_ph;
    sda_oe_n  = sda_oe;
    ld_b1     = 1'b0;
    commit    = 1'b0;
    if (start) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      ack_ph_n  = 1'b0;
      sda_oe_n  = 1'b0;
    end else if (stop) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      ack_ph_n  = 1'b0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ADDR, B1, B2: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_ph_n = 1'b0;
              if (state == ADDR) begin
                state_n = (byte_in[7:1] == DEV_ADDR && !byte_in[0]) ? ACK_A : WAIT_STOP;
              end else if (state == B1) begin
                ld_b1   = reg_ok;
                state_n = reg_ok ? ACK_1 : WAIT_STOP;
              end else begin
                commit  = 1'b1;
                state_n = ACK_2;
              end
            end
          end
        end
        ACK_A, ACK_1, ACK_2: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe_n = 1'b1;
              ack_ph_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              ack_ph_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = (state == ACK_A) ? B1 :
                          (state == ACK_1) ? B2 : WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // latch byte1 fields and publish committed writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reg_addr_q <= '0;
      d8_q       <= 1'b0;
      o_reg_wr   <= 1'b0;
      o_reg_addr <= '0;
      o_reg_data <= '0;
    end else begin
      o_reg_wr <= commit;
      if (ld_b1) begin
        reg_addr_q <= byte_in[7:1];
        d8_q       <= byte_in[0];
      end
      if (commit) begin
        o_reg_addr <= reg_addr_q;
        o_reg_data <= {d8_q, byte_in};
      end
    end
  end

  // register file: codec-reset address clears all, in-range addresses write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
    end else if (commit) begin
      if (reg_addr_q == REG_RESET) begin
        for (int i = 0; i < NREG; i++) regfile[i] <= '0;
      end else if (int'(reg_addr_q) < NREG) begin
        regfile[reg_addr_q[3:0]] <= {d8_q, byte_in};
      end
    end
  end

  // a START/STOP releases SDA in the very cycle it is seen
  assign o_sda_oe  = sda_oe & ~start & ~stop;
  assign o_busy    = (state != IDLE);
  assign o_rd_data = regfile[i_rd_addr];

endmodule

// File: doc/codec_i2c_responder.md
# codec_i2c_responder

I2C target (responder) that models the audio codec's control port: it accepts the same 3-byte register writes that the codec initializer issues and stores them in a local register file. It sits on the I2C bus opposite the initializer and serves two purposes: bus-level verification of the initializer, and a software-visible shadow of the codec configuration. It is write-only. Reads are NACKed.

## Interface
- DEV_ADDR, 7'h1A, 7-bit target address; the write address byte is 0x34.
- NREG, 16, register-file depth, indexed by reg_addr[3:0].
- i_clk  in  1  system clock; must be at least 16× the SCL rate.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_scl  in  1  raw I2C SCL (asynchronous).
- i_sda  in  1  raw I2C SDA (asynchronous).
- o_sda_oe  out  1  1 = pull SDA low (open-drain ACK); top ties SDA to 0 when set, otherwise Z.
- o_reg_wr  out  1  one-cycle pulse per committed register write.
- o_reg_addr  out  7  register address of the last commit.
- o_reg_data  out  9  data of the last commit.
- i_rd_addr  in  4  register-file read index.
- o_rd_data  out  9  combinational register-file read data.
- o_busy  out  1  high from START until STOP or abort.

## Operation
- Line conditioning: 2-flop synchronizers on SCL and SDA, then edge detection.
  - scl_rise / scl_fall: edges of synchronized SCL.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Byte format: 8 bits, MSB first, sampled on scl_rise.
  - byte0 = {addr[6:0], rw}.
  - byte1 = {reg_addr[6:0], data[8]}.
  - byte2 = data[7:0].
- States: IDLE, ADDR, ACK_A, B1, ACK_1, B2, ACK_2, WAIT_STOP.
- IDLE → ADDR on START. The bit counter clears on every START.
- ADDR, after the 8th bit:
  - addr==DEV_ADDR and rw==0 → ACK_A.
  - Any other value → WAIT_STOP with no ACK, SDA released.
- ACK_x handling:
  - o_sda_oe asserts on the scl_fall that ends the 8th bit.
  - o_sda_oe deasserts on the next scl_fall.
  - The state then advances to the next byte (ACK_A→B1, ACK_1→B2, ACK_2→WAIT_STOP).
- Commit: on the 8th scl_rise of B2:
  - o_reg_wr pulses on the next cycle; o_reg_addr/o_reg_data update that same cycle.
  - If reg_addr < NREG, regfile[reg_addr[3:0]] is written.
  - reg_addr 7'h0F (codec reset) clears every regfile entry to 0 instead.
- WAIT_STOP: any byte beyond byte2 is NACKed (SDA stays released) and nothing is written.
- STOP in any state → IDLE, o_sda_oe=0.
- Repeated START in any state → ADDR and aborts the transaction. A B2 in progress is not committed.
- STOP or START while o_sda_oe is asserted releases SDA in the same cycle the condition is detected.

## Timing
- Reset values (asynchronous, active-low): state IDLE; o_sda_oe 0; o_reg_wr 0; o_reg_addr 0; o_reg_data 0; o_busy 0; regfile all 0.
- Latency from raw pin to detected edge: 2–3 i_clk cycles (synchronizer plus edge register).
- ACK drive is valid before the 9th SCL rise, provided SCL low time is at least 4 i_clk.
- o_busy rises 1 cycle after START is detected and falls 1 cycle after STOP is detected.
- Reset asserted mid-transaction releases SDA immediately. After reset deasserts, the block waits for a fresh START.

## Configuration
- CODEC_REG_CHECK_EN defined:
  - reg_addr values outside {0..9, 15} are NACKed at ACK_1 and the state goes to WAIT_STOP.
  - No commit occurs.
- CODEC_REG_CHECK_EN undefined:
  - Every reg_addr is ACKed.
  - o_reg_wr still pulses for out-of-range addresses, but the regfile is written only when reg_addr < NREG.

## Structure
- Package codec_i2c_pkg holds:
  - the state enum;
  - DEV_ADDR_DEFAULT (7'h1A);
  - REG_RESET (7'h0F);
  - the valid-register mask used by CODEC_REG_CHECK_EN.
- Sub-module i2c_line_sync: synchronizers plus scl_rise, scl_fall, start and stop pulses. It is reusable by other I2C blocks.

## Test plan
- Write 0x34,0x08,0x15 then STOP → three ACKs; o_reg_wr pulses once with o_reg_addr=4, o_reg_data=9'h015; o_rd_data at index 4 = 9'h015.
- Address byte 0x36 (wrong address) or 0x35 (read) → no ACK on the 9th clock; no o_reg_wr; o_busy low after STOP.
- Write reg 2 = 9'h1FF (0x34,0x05,0xFF), then 0x34,0x1E,0x00 → regfile[2]=9'h1FF after the first write; all entries 0 after the second.
- Repeated START after 4 bits of byte2, then a full write of reg 7 = 9'h00A → no commit for the aborted transaction; one commit with addr 7, data 9'h00A.
- Assert i_rst_n low while o_sda_oe=1 → o_sda_oe=0 immediately; next transaction ACKs normally.
- With CODEC_REG_CHECK_EN, write 0x34,0x18,0x00 (reg 12) → ACK_A, NACK at ACK_1, no o_reg_wr. Without the macro → ACK and o_reg_wr pulse with addr 12; regfile[12]=0.
